// File: rtl/riscv_pkg.sv
// Shared types and encodings for the RV32I multicycle controller.
// Holds FSM state, opcode constants, ALUOp and ALUControl codes.
package riscv_pkg;

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        MEMADR,
        MEMREAD,
        MEMWB,
        MEMWRITE,
        EXECUTER,
        EXECUTEI,
        ALUWB,
        BRANCH,
        JAL
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_t;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

endpackage

// File: rtl/alu_decoder.sv
// ALU operation decode from ALUOp, funct3 and funct7 bit 5.
// Subtract only for R-type (op[5]) with funct7b5 set.
module alu_decoder
    import riscv_pkg::*;
(
    input  aluop_t     aluop_i,
    input  logic [2:0] funct3_i,
    input  logic       op5_i,
    input  logic       funct7b5_i,
    output logic [2:0] alucontrol_o
);

    // Map the FSM's ALU request onto the ALU operation code
    always_comb begin
        alucontrol_o = ALU_ADD;
        case (aluop_i)
            ALUOP_SUB: alucontrol_o = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3_i)
                    3'b000:  alucontrol_o = (op5_i & funct7b5_i) ? ALU_SUB : ALU_ADD;
                    3'b010:  alucontrol_o = ALU_SLT;
                    3'b110:  alucontrol_o = ALU_OR;
                    3'b111:  alucontrol_o = ALU_AND;
                    default: alucontrol_o = ALU_ADD;
                endcase
            end
            default: alucontrol_o = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RV32I control FSM with Moore output decode.
// Write enables are forced low while reset is held.
module multicycle_controller
    import riscv_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       IRWrite,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic [2:0] ALUControl,
    output logic       instr_done
);

    state_t state_q, state_d;
    aluop_t alu_op;
    logic   pc_update, branch, taken, op_ok;
    logic   ir_wr, mem_wr, reg_wr, done;

    // State register; reset returns to FETCH from anywhere
    always_ff @(posedge clk) begin
        if (reset) state_q <= FETCH;
        else       state_q <= state_d;
    end

    // Opcodes this controller knows how to sequence
    always_comb begin
        op_ok = 1'b0;
        case (op)
            OP_LW, OP_SW, OP_R, OP_I, OP_BR, OP_JAL: op_ok = 1'b1;
            default: op_ok = 1'b0;
        endcase
    end

    // Next-state selection
    always_comb begin
        state_d = FETCH;
        case (state_q)
            FETCH: state_d = DECODE;
            DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_R:         state_d = EXECUTER;
                    OP_I:         state_d = EXECUTEI;
                    OP_BR:        state_d = BRANCH;
                    OP_JAL:       state_d = JAL;
                    default:      state_d = FETCH;
                endcase
            end
            MEMADR:   state_d = (op == OP_SW) ? MEMWRITE : MEMREAD;
            MEMREAD:  state_d = MEMWB;
            EXECUTER: state_d = ALUWB;
            EXECUTEI: state_d = ALUWB;
            JAL:      state_d = ALUWB;
            default:  state_d = FETCH;
        endcase
    end

    // Moore decode of datapath controls from the current state
    always_comb begin
        pc_update = 1'b0;
        branch    = 1'b0;
        AdrSrc    = 1'b0;
        ir_wr     = 1'b0;
        mem_wr    = 1'b0;
        reg_wr    = 1'b0;
        done      = 1'b0;
        ResultSrc = 2'b00;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        alu_op    = ALUOP_ADD;
        case (state_q)
            FETCH: begin
                ir_wr     = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                pc_update = 1'b1;
            end
            DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                done    = ~op_ok;
            end
            MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            MEMREAD: AdrSrc = 1'b1;
            MEMWB: begin
                ResultSrc = 2'b01;
                reg_wr    = 1'b1;
                done      = 1'b1;
            end
            MEMWRITE: begin
                AdrSrc = 1'b1;
                mem_wr = 1'b1;
                done   = 1'b1;
            end
            EXECUTER: begin
                ALUSrcA = 2'b10;
                alu_op  = ALUOP_FUNCT;
            end
            EXECUTEI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                alu_op  = ALUOP_FUNCT;
            end
            ALUWB: begin
                reg_wr = 1'b1;
                done   = 1'b1;
            end
            BRANCH: begin
                ALUSrcA = 2'b10;
                alu_op  = ALUOP_SUB;
                branch  = 1'b1;
                done    = 1'b1;
            end
            JAL: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                pc_update = 1'b1;
            end
            default: ;
        endcase
    end

    // Branch condition: beq on zero, bne on not-zero
    always_comb begin
        case (funct3)
            3'b000:  taken = zero;
            3'b001:  taken = ~zero;
            default: taken = 1'b0;
        endcase
    end

    // Immediate format selected straight from the opcode
    always_comb begin
        case (op)
            OP_SW:   ImmSrc = 2'b01;
            OP_BR:   ImmSrc = 2'b10;
            OP_JAL:  ImmSrc = 2'b11;
            default: ImmSrc = 2'b00;
        endcase
    end

    assign PCWrite    = ~reset & (pc_update | (branch & taken));
    assign IRWrite    = ~reset & ir_wr;
    assign MemWrite   = ~reset & mem_wr;
    assign RegWrite   = ~reset & reg_wr;
    assign instr_done = ~reset & done;

    alu_decoder u_alu_dec (
        .aluop_i      (alu_op),
        .funct3_i     (funct3),
        .op5_i        (op[5]),
        .funct7b5_i   (funct7b5),
        .alucontrol_o (ALUControl)
    );

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller.
// Expected control words per state are hand-written constants.
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite, instr_done;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0] ALUControl;

    int n_checks = 0;
    int n_fail   = 0;

    localparam int T_F   = 0;
    localparam int T_D   = 1;
    localparam int T_DU  = 2;
    localparam int T_MA  = 3;
    localparam int T_MR  = 4;
    localparam int T_MWB = 5;
    localparam int T_MW  = 6;
    localparam int T_XR  = 7;
    localparam int T_XI  = 8;
    localparam int T_AWB = 9;
    localparam int T_BR  = 10;
    localparam int T_JAL = 11;

    // {PCWrite,AdrSrc,IRWrite,MemWrite,RegWrite,ResultSrc,ALUSrcA,ALUSrcB,instr_done}
    logic [11:0] obs;
    assign obs = {PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite,
                  ResultSrc, ALUSrcA, ALUSrcB, instr_done};

    multicycle_controller dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .zero       (zero),
        .PCWrite    (PCWrite),
        .AdrSrc     (AdrSrc),
        .IRWrite    (IRWrite),
        .MemWrite   (MemWrite),
        .RegWrite   (RegWrite),
        .ResultSrc  (ResultSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ImmSrc     (ImmSrc),
        .ALUControl (ALUControl),
        .instr_done (instr_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [11:0] exp_vec(input int s, input bit tk);
        case (s)
            T_F:     return 12'b1_0_1_0_0_10_00_10_0;
            T_D:     return 12'b0_0_0_0_0_00_01_01_0;
            T_DU:    return 12'b0_0_0_0_0_00_01_01_1;
            T_MA:    return 12'b0_0_0_0_0_00_10_01_0;
            T_MR:    return 12'b0_1_0_0_0_00_00_00_0;
            T_MWB:   return 12'b0_0_0_0_1_01_00_00_1;
            T_MW:    return 12'b0_1_0_1_0_00_00_00_1;
            T_XR:    return 12'b0_0_0_0_0_00_10_00_0;
            T_XI:    return 12'b0_0_0_0_0_00_10_01_0;
            T_AWB:   return 12'b0_0_0_0_1_00_00_00_1;
            T_BR:    return {tk, 11'b0_0_0_0_00_10_00_1};
            T_JAL:   return 12'b1_0_0_0_0_00_01_10_0;
            default: return 12'b0;
        endcase
    endfunction

    function automatic logic [2:0] exp_aluc(input int s, input logic [2:0] fn);
        case (s)
            T_BR:       return 3'b001;
            T_XR, T_XI: return fn;
            default:    return 3'b000;
        endcase
    endfunction

    // Runs n states of one instruction, checking every cycle
    task automatic run_seq(input string nm, input logic [6:0] o,
                           input logic [2:0] f3, input logic f7,
                           input logic z, input bit tk,
                           input logic [2:0] fn, input logic [1:0] imm,
                           input int n, input int s0, input int s1,
                           input int s2, input int s3, input int s4);
        int st [5];
        st = '{s0, s1, s2, s3, s4};
        op = o; funct3 = f3; funct7b5 = f7; zero = z;
        for (int i = 0; i < n; i++) begin
            #1;
            check($sformatf("%s c%0d ctl", nm, i + 1), 32'(obs),
                  32'(exp_vec(st[i], tk)));
            check($sformatf("%s c%0d aluc", nm, i + 1), 32'(ALUControl),
                  32'(exp_aluc(st[i], fn)));
            check($sformatf("%s c%0d imm", nm, i + 1), 32'(ImmSrc),
                  32'(imm));
            @(negedge clk);
        end
    endtask

    initial begin
        reset = 1'b1; op = 7'b0; funct3 = 3'b0; funct7b5 = 1'b0; zero = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("reset gated", 32'(obs), 32'(12'b0_0_0_0_0_10_00_10_0));
        reset = 1'b0;

        run_seq("lw", 7'b0000011, 3'b010, 1'b0, 1'b0, 1'b0, 3'b000, 2'b00,
                5, T_F, T_D, T_MA, T_MR, T_MWB);
        run_seq("sw", 7'b0100011, 3'b010, 1'b0, 1'b0, 1'b0, 3'b000, 2'b01,
                4, T_F, T_D, T_MA, T_MW, T_F);
        run_seq("sub", 7'b0110011, 3'b000, 1'b1, 1'b0, 1'b0, 3'b001, 2'b00,
                4, T_F, T_D, T_XR, T_AWB, T_F);
        run_seq("and", 7'b0110011, 3'b111, 1'b0, 1'b0, 1'b0, 3'b010, 2'b00,
                4, T_F, T_D, T_XR, T_AWB, T_F);
        run_seq("or", 7'b0110011, 3'b110, 1'b0, 1'b0, 1'b0, 3'b011, 2'b00,
                4, T_F, T_D, T_XR, T_AWB, T_F);
        run_seq("slti", 7'b0010011, 3'b010, 1'b0, 1'b0, 1'b0, 3'b101, 2'b00,
                4, T_F, T_D, T_XI, T_AWB, T_F);
        run_seq("addi f7", 7'b0010011, 3'b000, 1'b1, 1'b0, 1'b0, 3'b000, 2'b00,
                4, T_F, T_D, T_XI, T_AWB, T_F);
        run_seq("xori", 7'b0010011, 3'b100, 1'b0, 1'b0, 1'b0, 3'b000, 2'b00,
                4, T_F, T_D, T_XI, T_AWB, T_F);
        run_seq("beq z1", 7'b1100011, 3'b000, 1'b0, 1'b1, 1'b1, 3'b000, 2'b10,
                3, T_F, T_D, T_BR, T_F, T_F);
        run_seq("beq z0", 7'b1100011, 3'b000, 1'b0, 1'b0, 1'b0, 3'b000, 2'b10,
                3, T_F, T_D, T_BR, T_F, T_F);
        run_seq("bne z0", 7'b1100011, 3'b001, 1'b0, 1'b0, 1'b1, 3'b000, 2'b10,
                3, T_F, T_D, T_BR, T_F, T_F);
        run_seq("bne z1", 7'b1100011, 3'b001, 1'b0, 1'b1, 1'b0, 3'b000, 2'b10,
                3, T_F, T_D, T_BR, T_F, T_F);
        run_seq("blt z1", 7'b1100011, 3'b100, 1'b0, 1'b1, 1'b0, 3'b000, 2'b10,
                3, T_F, T_D, T_BR, T_F, T_F);
        run_seq("jal", 7'b1101111, 3'b000, 1'b0, 1'b0, 1'b0, 3'b000, 2'b11,
                4, T_F, T_D, T_JAL, T_AWB, T_F);
        run_seq("unsup", 7'b0000000, 3'b000, 1'b0, 1'b0, 1'b0, 3'b000, 2'b00,
                2, T_F, T_DU, T_F, T_F, T_F);
        run_seq("after unsup", 7'b0110011, 3'b000, 1'b0, 1'b0, 1'b0, 3'b000,
                2'b00, 4, T_F, T_D, T_XR, T_AWB, T_F);

        // reset held three cycles from the middle of MEMREAD
        run_seq("lw pre", 7'b0000011, 3'b010, 1'b0, 1'b0, 1'b0, 3'b000, 2'b00,
                3, T_F, T_D, T_MA, T_F, T_F);
        #1;
        check("in MEMREAD", 32'(obs), 32'(exp_vec(T_MR, 1'b0)));
        reset = 1'b1;
        #1;
        check("rst in MEMREAD", 32'(obs), 32'(exp_vec(T_MR, 1'b0)));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            check($sformatf("rst hold %0d", i + 1), 32'(obs),
                  32'(12'b0_0_0_0_0_10_00_10_0));
        end
        reset = 1'b0;
        #1;
        check("rel PCWrite", 32'(PCWrite), 32'd1);
        check("rel IRWrite", 32'(IRWrite), 32'd1);
        run_seq("lw post", 7'b0000011, 3'b010, 1'b0, 1'b0, 1'b0, 3'b000, 2'b00,
                5, T_F, T_D, T_MA, T_MR, T_MWB);

        // reset in ALUWB suppresses RegWrite and instr_done
        run_seq("r pre", 7'b0110011, 3'b000, 1'b0, 1'b0, 1'b0, 3'b000, 2'b00,
                3, T_F, T_D, T_XR, T_F, T_F);
        reset = 1'b1;
        #1;
        check("rst in ALUWB", 32'(obs), 32'(12'b0));
        @(negedge clk);
        reset = 1'b0;
        run_seq("sw post", 7'b0100011, 3'b010, 1'b0, 1'b0, 1'b0, 3'b000, 2'b01,
                4, T_F, T_D, T_MA, T_MW, T_F);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 SHALL have no parameters; all widths are fixed by the RV32I subset.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 op  in  7  opcode, Instr[6:0].
REQ-005 funct3  in  3  Instr[14:12].
REQ-006 funct7b5  in  1  Instr[30].
REQ-007 zero  in  1  ALU zero flag.
REQ-008 PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite  out  1 each  datapath enables/selects.
REQ-009 ResultSrc, ALUSrcA, ALUSrcB, ImmSrc  out  2 each  mux selects; ImmSrc drives the immediate extender.
REQ-010 ALUControl  out  3  ALU operation.
REQ-011 instr_done  out  1  one-cycle pulse on the last cycle of each instruction.

Function
REQ-012 Main FSM states SHALL be FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BRANCH, JAL; one transition per clock.
REQ-013 Transitions: FETCH->DECODE; DECODE: lw 0000011 / sw 0100011 ->MEMADR, 0110011->EXECUTER, 0010011->EXECUTEI, 1100011->BRANCH, 1101111->JAL, any other op->FETCH.
REQ-014 MEMADR->MEMREAD (lw) or MEMWRITE (sw); MEMREAD->MEMWB; EXECUTER, EXECUTEI, JAL->ALUWB; MEMWB, MEMWRITE, ALUWB, BRANCH->FETCH.
REQ-015 Outputs SHALL be Moore decodes of state (plus zero for PCWrite); unlisted outputs are 0.
REQ-016 FETCH: IRWrite=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ResultSrc=10, ALUOp=add, PCUpdate=1.
REQ-017 DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=add. MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=add.
REQ-018 MEMREAD: AdrSrc=1, ResultSrc=00. MEMWB: ResultSrc=01, RegWrite=1. MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1.
REQ-019 EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=funct. EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=funct. ALUWB: ResultSrc=00, RegWrite=1.
REQ-020 BRANCH: ALUSrcA=10, ALUSrcB=00, ALUOp=sub, ResultSrc=00, Branch=1. JAL: ALUSrcA=01, ALUSrcB=10, ResultSrc=00, PCUpdate=1.
REQ-021 PCWrite = PCUpdate | (Branch & taken); taken = zero when funct3=000 (beq), ~zero when funct3=001 (bne), 0 otherwise.
REQ-022 ImmSrc SHALL be combinational from op: 0000011/0010011->00, 0100011->01, 1100011->10, 1101111->11, other->00.
REQ-023 ALU decode: ALUOp add->000, sub->001; funct: funct3 000 -> 001 if op[5]&funct7b5 else 000; 010->101; 110->011; 111->010; other funct3->000.
REQ-024 instr_done SHALL be 1 in MEMWB, MEMWRITE, ALUWB, BRANCH, and in DECODE when op is unsupported.
REQ-025 Latency: lw 5, sw 4, R/I-type 4, branch 3, jal 4, unsupported 2 cycles.

Reset
REQ-026 reset high at a rising edge SHALL force state to FETCH from any state, including mid-instruction.
REQ-027 While reset is high, PCWrite, IRWrite, MemWrite, RegWrite, instr_done SHALL be 0; other outputs decode the current state.
REQ-028 First cycle after reset deasserts SHALL be FETCH with REQ-016 values.

Structure
REQ-029 Shared package riscv_pkg SHALL hold the state enum, opcode constants, ALUOp and ALUControl encodings.
REQ-030 ALU decoding (REQ-023) SHALL be a sub-module alu_decoder; FSM and ImmSrc decode stay in the top.

Verification
REQ-031 Reset held 3 cycles mid-MEMREAD -> write enables 0 during reset; FETCH with IRWrite=1, PCWrite=1 on first cycle after release.
REQ-032 lw (op=0000011) -> FETCH, DECODE, MEMADR, MEMREAD, MEMWB; RegWrite=1 and ResultSrc=01 only in cycle 5; instr_done on cycle 5.
REQ-033 R-type sub (op=0110011, funct3=000, funct7b5=1) -> EXECUTER with ALUControl=001, ALUWB RegWrite=1, 4 cycles.
REQ-034 beq with zero=1 -> PCWrite=1 in BRANCH; repeat with zero=0 -> PCWrite=0; bne (funct3=001), zero=0 -> PCWrite=1.
REQ-035 jal (op=1101111) -> ImmSrc=11, JAL PCWrite=1, ALUWB RegWrite=1; unsupported op=0000000 -> DECODE->FETCH, instr_done=1, no write enable.
